// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_mem_pkg
// Description : Shared types for the MEM-stage load/store unit: memory
//               operation encoding, FSM state encoding and op helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_t;

    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_LD_RD   = 3'd1;
    localparam logic [2:0] C_ST_LD_CAP  = 3'd2;
    localparam logic [2:0] C_ST_ST_WR   = 3'd3;
    localparam logic [2:0] C_ST_RMW_RD  = 3'd4;
    localparam logic [2:0] C_ST_RMW_MRG = 3'd5;
    localparam logic [2:0] C_ST_RMW_WR  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = C_ST_IDLE,
        ST_LD_RD   = C_ST_LD_RD,
        ST_LD_CAP  = C_ST_LD_CAP,
        ST_ST_WR   = C_ST_ST_WR,
        ST_RMW_RD  = C_ST_RMW_RD,
        ST_RMW_MRG = C_ST_RMW_MRG,
        ST_RMW_WR  = C_ST_RMW_WR
    } lsu_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Word ops need 4-byte alignment, halfword ops 2-byte; bytes never misalign.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] offs);
        logic r;
        case (op)
            OP_LW, OP_SW:         r = (offs != 2'b00);
            OP_LH, OP_LHU, OP_SH: r = offs[0];
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational little-endian lane steering.
//               Load path : picks byte/half/word from a memory word and
//                           sign- or zero-extends it.
//               Store path: merges a right-justified byte/half into the
//                           old memory word (SW passes wdata through).
// Ports       : word       old / read memory word
//               offs       byte offset addr[1:0]
//               op         mem_op_t encoding
//               wdata      right-justified store data
//               load_data  extended load result
//               store_word merged word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offs,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    mem_op_t     w_op;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_op = mem_op_t'(op);

        case (offs)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = offs[1] ? word[31:16] : word[15:0];

        case (w_op)
            OP_LB:   load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  load_data = {24'd0, w_byte};
            OP_LH:   load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  load_data = {16'd0, w_half};
            default: load_data = word;
        endcase

        // Untouched lanes keep the value read from memory.
        store_word = word;
        case (w_op)
            OP_SB: begin
                case (offs)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (offs[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage initiator for a word-addressed, 1-cycle-latency
//               synchronous data memory. Accepts byte-addressed requests via
//               valid/ready, issues one-cycle read/write strobes, performs
//               read-modify-write for SH/SB, extends loads and reports
//               misaligned / out-of-range requests.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_ready/req_op/req_addr/req_wdata  request side
//               resp_valid/resp_rdata/resp_err                 response pulse
//               mem_read/mem_write/mem_addr/mem_wdata/mem_rdata memory side
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_offs;
    logic [31:0] r_wdata;

    mem_op_t     w_req_op;
    logic        w_bad;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_req_op  = mem_op_t'(req_op);
    assign w_bad     = is_misaligned(w_req_op, req_addr[1:0])
                     || (req_addr[31:MEM_AW+2] != '0);
    assign req_ready = (r_state == ST_IDLE);

    // Operates on the word returned by the memory in LD_CAP / RMW_MRG.
    lsu_lane_align u_lane_align (
        .word       (mem_rdata),
        .offs       (r_offs),
        .op         (r_op),
        .wdata      (r_wdata),
        .load_data  (w_load_data),
        .store_word (w_store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 3'd0;
            r_offs     <= 2'd0;
            r_wdata    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            // Strobes and response are single-cycle pulses by default.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op     <= req_op;
                        r_offs   <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        mem_addr <= req_addr[MEM_AW+1:2];
                        if (w_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (w_req_op == OP_SW) begin
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                            r_state   <= ST_ST_WR;
                        end else if (is_store(w_req_op)) begin
                            mem_read <= 1'b1;
                            r_state  <= ST_RMW_RD;
                        end else begin
                            mem_read <= 1'b1;
                            r_state  <= ST_LD_RD;
                        end
                    end
                end
                ST_LD_RD:   r_state <= ST_LD_CAP;
                ST_LD_CAP: begin
                    resp_rdata <= w_load_data;
                    resp_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_ST_WR: begin
                    resp_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_RMW_RD:  r_state <= ST_RMW_MRG;
                ST_RMW_MRG: begin
                    mem_wdata <= w_store_word;
                    mem_write <= 1'b1;
                    r_state   <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    resp_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a behavioural
//               word memory responder and a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import mips_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.MEM_AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory responder ----------------
    logic [31:0] mem [0:255];
    logic        mem_clear;
    logic        mem_rst_n;
    assign mem_rst_n = ~rst;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (mem_write && !mem_read) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk or negedge mem_rst_n) begin
        if (!mem_rst_n)    mem_rdata <= 32'd0;
        else if (mem_read) mem_rdata <= mem[mem_addr];
    end

    // ---------------- reference model (byte array) ----------------
    logic [7:0] rb [0:1023];

    function automatic logic ref_err(input logic [2:0] op, input logic [31:0] addr);
        mem_op_t o = mem_op_t'(op);
        longint unsigned a = addr;
        logic mis;
        mis = ((o == OP_LW || o == OP_SW) && (a % 4 != 0)) ||
              ((o == OP_LH || o == OP_LHU || o == OP_SH) && (a % 2 != 0));
        return mis || (a >= 1024);
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b = a - (a % 4);
        return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
        mem_op_t o = mem_op_t'(op);
        int v;
        case (o)
            OP_LB:  begin v = rb[a]; if (v > 127) v = v - 256; end
            OP_LBU: v = rb[a];
            OP_LH:  begin v = rb[a] + 256 * rb[a+1]; if (v > 32767) v = v - 65536; end
            OP_LHU: v = rb[a] + 256 * rb[a+1];
            default: return ref_word(a);
        endcase
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [2:0] op, input int a, input logic [31:0] wd);
        mem_op_t o = mem_op_t'(op);
        int n;
        n = (o == OP_SW) ? 4 : (o == OP_SH) ? 2 : 1;
        for (int k = 0; k < n; k++) rb[a+k] = 8'((wd >> (8 * k)) % 256);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and observe it cycle by cycle until its response.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int rd_cnt, output int wr_cnt, output int rd_cyc, output int wr_cyc,
                         output logic [31:0] wr_data, output logic [7:0] wr_addr,
                         output int bad, output logic after);
        rdata = 32'hx; err = 1'bx; lat = -1; rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0;
        wr_data = 32'h0; wr_addr = 8'h0; bad = 0; after = 1'b0;
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            if (mem_read)  begin rd_cnt++; rd_cyc = c; end
            if (mem_write) begin wr_cnt++; wr_cyc = c; wr_data = mem_wdata; wr_addr = mem_addr; end
            if (mem_read && mem_write) bad++;
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                if (!req_ready) bad++;
                break;
            end
            if (req_ready) bad++;
            @(posedge clk); #1;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            after = resp_valid | mem_read | mem_write;
        end
    endtask

    task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic [31:0] exp_wword);
        logic [31:0] rdata, wr_data;
        logic [7:0]  wr_addr;
        logic        err, after;
        int lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc, bad;
        int exp_lat, exp_rd, exp_wr, exp_wcyc;
        mem_op_t o = mem_op_t'(op);
        issue(op, addr, wdata, rdata, err, lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc, wr_data, wr_addr, bad, after);
        if (exp_err)                        begin exp_lat = 1; exp_rd = 0; exp_wr = 0; exp_wcyc = 0; end
        else if (o == OP_SW)                begin exp_lat = 2; exp_rd = 0; exp_wr = 1; exp_wcyc = 1; end
        else if (o == OP_SH || o == OP_SB)  begin exp_lat = 4; exp_rd = 1; exp_wr = 1; exp_wcyc = 3; end
        else                                begin exp_lat = 3; exp_rd = 1; exp_wr = 0; exp_wcyc = 0; end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".reads"}, 32'(rd_cnt), 32'(exp_rd));
        check({tag, ".writes"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, ".protocol"}, 32'(bad), 32'd0);
        check({tag, ".pulse"}, {31'd0, after}, 32'd0);
        if (exp_rd != 0) check({tag, ".rd_cycle"}, 32'(rd_cyc), 32'd1);
        if (exp_wr != 0) begin
            check({tag, ".wr_cycle"}, 32'(wr_cyc), 32'(exp_wcyc));
            check({tag, ".wr_data"}, wr_data, exp_wword);
            check({tag, ".wr_addr"}, {24'd0, wr_addr}, {24'd0, addr[9:2]});
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs [25];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset ----
        rst = 1'b1; mem_clear = 1'b1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_err", {31'd0, resp_err}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst.mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0; mem_clear = 1'b0;

        // ---- directed table (memory starts zeroed) ----
        vecs[0]  = '{OP_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1]  = '{OP_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2]  = '{OP_LB,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 32'h0};
        vecs[3]  = '{OP_LBU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 32'h0};
        vecs[4]  = '{OP_LH,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 32'h0};
        vecs[5]  = '{OP_LHU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 32'h0};
        vecs[6]  = '{OP_SB,  32'h11, 32'hAA,       32'h0,        1'b0, 32'hDEADAAEF};
        vecs[7]  = '{OP_LW,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 32'h0};
        vecs[8]  = '{OP_SH,  32'h12, 32'h1234,     32'h0,        1'b0, 32'h1234AAEF};
        vecs[9]  = '{OP_LW,  32'h10, 32'h0,        32'h1234AAEF, 1'b0, 32'h0};
        vecs[10] = '{OP_LW,  32'h12, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[11] = '{OP_SH,  32'h13, 32'h5555,     32'h0,        1'b1, 32'h0};
        vecs[12] = '{OP_LW,  32'h400, 32'h0,       32'h0,        1'b1, 32'h0};
        vecs[13] = '{OP_LW,  32'h10, 32'h0,        32'h1234AAEF, 1'b0, 32'h0};
        vecs[14] = '{OP_LB,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 32'h0};
        vecs[15] = '{OP_LH,  32'h10, 32'h0,        32'hFFFFAAEF, 1'b0, 32'h0};
        vecs[16] = '{OP_LHU, 32'h12, 32'h0,        32'h00001234, 1'b0, 32'h0};
        vecs[17] = '{OP_SB,  32'h3FF, 32'h80,      32'h0,        1'b0, 32'h80000000};
        vecs[18] = '{OP_LB,  32'h3FF, 32'h0,       32'hFFFFFF80, 1'b0, 32'h0};
        vecs[19] = '{OP_LHU, 32'h11, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[20] = '{OP_SW,  32'h12, 32'h11111111, 32'h0,        1'b1, 32'h0};
        vecs[21] = '{OP_SB,  32'h80000000, 32'h1,  32'h0,        1'b1, 32'h0};
        vecs[22] = '{OP_LW,  32'h3FC, 32'h0,       32'h80000000, 1'b0, 32'h0};
        vecs[23] = '{OP_SB,  32'h3FE, 32'hFFFFFF7F, 32'h0,       1'b0, 32'h807F0000};
        vecs[24] = '{OP_LH,  32'h3FE, 32'h0,       32'hFFFF807F, 1'b0, 32'h0};
        for (int i = 0; i < 25; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_wword);
        check("err.mem_unchanged", mem[4], 32'h1234AAEF);

        // ---- back-to-back with req_valid held: LW 0x10, SB 0x21, SW 0x24 ----
        begin
            logic [2:0]  op5 [3];
            logic [31:0] ad5 [3];
            logic [31:0] wd5 [3];
            int          rcyc [3];
            logic [31:0] rdat [3];
            int n_acc = 0, n_resp = 0, both = 0, busybad = 0;
            logic acc;
            op5[0] = OP_LW; ad5[0] = 32'h10; wd5[0] = 32'h0;
            op5[1] = OP_SB; ad5[1] = 32'h21; wd5[1] = 32'h5A;
            op5[2] = OP_SW; ad5[2] = 32'h24; wd5[2] = 32'hCAFEF00D;
            for (int k = 0; k < 3; k++) begin rcyc[k] = -100; rdat[k] = 32'hx; end
            @(negedge clk);
            req_valid = 1'b1; req_op = op5[0]; req_addr = ad5[0]; req_wdata = wd5[0];
            for (int c = 0; c < 40 && n_resp < 3; c++) begin
                #1;
                acc = req_valid && req_ready;
                @(posedge clk); #1;
                if (acc) begin
                    n_acc++;
                    if (n_acc < 3) begin
                        req_op = op5[n_acc]; req_addr = ad5[n_acc]; req_wdata = wd5[n_acc];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
                if (mem_read && mem_write) both++;
                if (resp_valid) begin
                    rcyc[n_resp] = c; rdat[n_resp] = resp_rdata; n_resp++;
                end else if (n_acc > n_resp && req_ready) begin
                    busybad++;
                end
                @(negedge clk);
            end
            req_valid = 1'b0;
            check("b2b.responses", 32'(n_resp), 32'd3);
            check("b2b.lw_cycle", 32'(rcyc[0]), 32'd2);
            check("b2b.sb_gap", 32'(rcyc[1] - rcyc[0]), 32'd4);
            check("b2b.sw_gap", 32'(rcyc[2] - rcyc[1]), 32'd2);
            check("b2b.lw_data", rdat[0], 32'h1234AAEF);
            check("b2b.store_data", rdat[1] | rdat[2], 32'h0);
            check("b2b.both_strobes", 32'(both), 32'd0);
            check("b2b.ready_busy", 32'(busybad), 32'd0);
            check("b2b.word8", mem[8], 32'h00005A00);
            check("b2b.word9", mem[9], 32'hCAFEF00D);
        end

        // ---- reset in RMW_MRG of SB 0x20 ----
        begin
            int rv = 0;
            @(negedge clk);
            req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h20; req_wdata = 32'h77;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("rstmid.rmw_read", {31'd0, mem_read}, 32'd1);
            @(posedge clk); #1;
            rst = 1'b1; #1;
            check("rstmid.strobes", {30'd0, mem_read, mem_write}, 32'd0);
            check("rstmid.ready", {31'd0, req_ready}, 32'd1);
            @(posedge clk); #1;
            check("rstmid.no_write", {31'd0, mem_write}, 32'd0);
            @(negedge clk); rst = 1'b0;
            repeat (4) begin @(posedge clk); #1; if (resp_valid) rv++; end
            check("rstmid.no_resp", 32'(rv), 32'd0);
            check("rstmid.word8", mem[8], 32'h00005A00);
            run_vec("rstmid.lw", OP_LW, 32'h20, 32'h0, 32'h00005A00, 1'b0, 32'h0);
        end

        // ---- reset while a load's read strobe is high ----
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h24; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0; #1;
        rst = 1'b1; #1;
        check("rstld.read_drop", {31'd0, mem_read}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // ---- randomized traffic against the byte-array model ----
        for (int w = 0; w < 256; w++) begin
            rb[4*w]   = mem[w][7:0];
            rb[4*w+1] = mem[w][15:8];
            rb[4*w+2] = mem[w][23:16];
            rb[4*w+3] = mem[w][31:24];
        end
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  op;
            logic [31:0] addr, wd, er, ew;
            logic        ee;
            op   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = addr | (32'd1 << $urandom_range(10, 31));
            wd = $urandom;
            ee = ref_err(op, addr);
            er = 32'h0; ew = 32'h0;
            if (!ee) begin
                if (is_store(mem_op_t'(op))) begin
                    ref_store(op, int'(addr), wd);
                    ew = ref_word(int'(addr));
                end else begin
                    er = ref_load(op, int'(addr));
                end
            end
            run_vec($sformatf("rnd%0d", n), op, addr, wd, er, ee, ew);
        end
        for (int w = 0; w < 16; w++)
            check($sformatf("rnd.mem%0d", w), mem[w], ref_word(4 * w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
